// File: rtl/donut_march_sched_if.sv
// rtl/donut_march_sched_if.sv - job, engine and result bus of the donut ray-march sequencer
interface donut_march_sched_if #(
  parameter int TAG_W   = 10,
  parameter int SHADE_W = 4
);
  logic               req_valid;
  logic               req_ready;
  logic [TAG_W-1:0]   req_tag;
  logic signed [15:0] req_px, req_py, req_pz;
  logic signed [15:0] req_rx, req_ry, req_rz;
  logic signed [15:0] cfg_lx, cfg_ly, cfg_lz;

  logic               eng_start;
  logic signed [15:0] eng_px, eng_py, eng_pz;
  logic signed [15:0] eng_rx, eng_ry, eng_rz;
  logic signed [15:0] eng_lx, eng_ly, eng_lz;
  logic               eng_hit;
  logic signed [15:0] eng_light;

  logic               out_valid;
  logic               out_ready;
  logic [TAG_W-1:0]   out_tag;
  logic               out_hit;
  logic [SHADE_W-1:0] out_shade;

  modport master (
    output req_valid, req_tag, req_px, req_py, req_pz, req_rx, req_ry, req_rz,
           cfg_lx, cfg_ly, cfg_lz, eng_hit, eng_light, out_ready,
    input  req_ready, eng_start, eng_px, eng_py, eng_pz, eng_rx, eng_ry, eng_rz,
           eng_lx, eng_ly, eng_lz, out_valid, out_tag, out_hit, out_shade
  );

  modport slave (
    input  req_valid, req_tag, req_px, req_py, req_pz, req_rx, req_ry, req_rz,
           cfg_lx, cfg_ly, cfg_lz, eng_hit, eng_light, out_ready,
    output req_ready, eng_start, eng_px, eng_py, eng_pz, eng_rx, eng_ry, eng_rz,
           eng_lx, eng_ly, eng_lz, out_valid, out_tag, out_hit, out_shade
  );
endinterface

// File: rtl/donut_march_sched.sv
// rtl/donut_march_sched.sv - sequencer that launches the shared ray-march engine and returns shaded results
module donut_march_sched #(
  parameter int STEPS       = 8,
  parameter int TAG_W       = 10,
  parameter int SHADE_W     = 4,
  parameter int SHADE_SHIFT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              abort,
  output logic              busy,
  donut_march_sched_if.slave bus
);
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic signed [15:0] SHADE_MAX = 16'((1 << SHADE_W) - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, MARCH, DONE} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic               req_ready;
  logic               accept;
  logic               sample;
  logic [TAG_W-1:0]   job_tag;
  logic signed [15:0] light_s;
  logic [SHADE_W-1:0] shade;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    sample    = 1'b0;
    case (state)
      IDLE:   req_ready = 1'b1;
      LAUNCH: state_n = MARCH;
      MARCH: begin
        if (cnt == CNT_W'(STEPS)) begin
          sample  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          req_ready = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // abort wins over both handshakes and over the end-of-march sample
    if (reset || abort) begin
      req_ready = 1'b0;
      sample    = 1'b0;
      state_n   = IDLE;
    end
    accept = req_ready & bus.req_valid;
    if (accept) state_n = LAUNCH;
  end

  assign bus.req_ready = req_ready;
  assign busy          = (state != IDLE);

  always_comb begin
    light_s = bus.eng_light >>> SHADE_SHIFT;
    if (!bus.eng_hit || light_s[15]) shade = '0;
    else if (light_s > SHADE_MAX)   shade = '1;
    else                            shade = light_s[SHADE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      bus.eng_start <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_tag   <= '0;
      bus.out_hit   <= 1'b0;
      bus.out_shade <= '0;
      job_tag       <= '0;
      bus.eng_px    <= '0;
      bus.eng_py    <= '0;
      bus.eng_pz    <= '0;
      bus.eng_rx    <= '0;
      bus.eng_ry    <= '0;
      bus.eng_rz    <= '0;
      bus.eng_lx    <= '0;
      bus.eng_ly    <= '0;
      bus.eng_lz    <= '0;
    end else begin
      bus.eng_start <= (state_n == LAUNCH);
      bus.out_valid <= (state_n == DONE);

      if (abort)                      cnt <= '0;
      else if (state == LAUNCH)       cnt <= CNT_W'(1);
      else if (state == MARCH && !sample) cnt <= cnt + 1'b1;

      // operand registers drive the engine directly, so they only move on accept
      if (accept) begin
        job_tag    <= bus.req_tag;
        bus.eng_px <= bus.req_px;
        bus.eng_py <= bus.req_py;
        bus.eng_pz <= bus.req_pz;
        bus.eng_rx <= bus.req_rx;
        bus.eng_ry <= bus.req_ry;
        bus.eng_rz <= bus.req_rz;
        bus.eng_lx <= bus.cfg_lx;
        bus.eng_ly <= bus.cfg_ly;
        bus.eng_lz <= bus.cfg_lz;
      end

      if (sample) begin
        bus.out_tag   <= job_tag;
        bus.out_hit   <= bus.eng_hit;
        bus.out_shade <= shade;
      end
    end
  end
endmodule

// File: tb/tb_donut_march_sched.sv
// tb/tb_donut_march_sched.sv - directed self-checking bench for donut_march_sched
module tb_donut_march_sched;
  localparam int STEPS   = 8;
  localparam int TAG_W   = 10;
  localparam int SHADE_W = 4;

  logic clk = 1'b0;
  logic reset;
  logic abort;
  logic busy;
  int   n_checks = 0;
  int   n_fail   = 0;

  donut_march_sched_if #(.TAG_W(TAG_W), .SHADE_W(SHADE_W)) bus ();

  donut_march_sched #(
    .STEPS(STEPS), .TAG_W(TAG_W), .SHADE_W(SHADE_W), .SHADE_SHIFT(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .abort(abort),
    .busy (busy),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_job(input logic [TAG_W-1:0] tag, input logic [15:0] base);
    bus.req_tag = tag;
    bus.req_px  = base;
    bus.req_py  = base + 16'd1;
    bus.req_pz  = base + 16'd2;
    bus.req_rx  = base + 16'd3;
    bus.req_ry  = base + 16'd4;
    bus.req_rz  = base + 16'd5;
    bus.cfg_lx  = base + 16'd6;
    bus.cfg_ly  = base + 16'd7;
    bus.cfg_lz  = base + 16'd8;
  endtask

  task automatic scramble();
    bus.req_tag = TAG_W'($urandom);
    bus.req_px  = 16'($urandom);
    bus.req_py  = 16'($urandom);
    bus.req_pz  = 16'($urandom);
    bus.req_rx  = 16'($urandom);
    bus.req_ry  = 16'($urandom);
    bus.req_rz  = 16'($urandom);
    bus.cfg_lx  = 16'($urandom);
    bus.cfg_ly  = 16'($urandom);
    bus.cfg_lz  = 16'($urandom);
  endtask

  function automatic int op_err(input logic [15:0] base);
    logic [15:0] ops [9];
    int e = 0;
    ops = '{bus.eng_px, bus.eng_py, bus.eng_pz, bus.eng_rx, bus.eng_ry,
            bus.eng_rz, bus.eng_lx, bus.eng_ly, bus.eng_lz};
    for (int i = 0; i < 9; i++) if (ops[i] !== base + 16'(i)) e++;
    return e;
  endfunction

  // Engine result is only valid from the cycle it is sampled; before that a decoy is driven.
  task automatic run_job(input logic [TAG_W-1:0] tag, input logic [15:0] base,
                         input logic [15:0] light, input logic hit, input logic [3:0] exp_shade);
    int n, starts, herr;
    drive_job(tag, base);
    bus.eng_light = 16'h0C00;
    bus.eng_hit   = ~hit;
    bus.out_ready = 1'b1;
    bus.req_valid = 1'b1;
    #1 check($sformatf("req_ready_idle_%0h", tag), bus.req_ready, 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check($sformatf("eng_start_%0h", tag), bus.eng_start, 1);
    check($sformatf("busy_%0h", tag), busy, 1);
    n = 0;
    starts = 0;
    herr = op_err(base);
    scramble();
    while (!bus.out_valid && n < 30) begin
      @(negedge clk);
      n++;
      if (bus.eng_start) starts++;
      if (!bus.out_valid) herr += op_err(base);
      scramble();
      if (n == STEPS) begin
        bus.eng_light = light;
        bus.eng_hit   = hit;
      end
    end
    check($sformatf("latency_%0h", tag), n, STEPS + 1);
    check($sformatf("single_start_%0h", tag), starts, 0);
    check($sformatf("operand_hold_%0h", tag), herr, 0);
    check($sformatf("out_tag_%0h", tag), bus.out_tag, tag);
    check($sformatf("out_hit_%0h", tag), bus.out_hit, hit);
    check($sformatf("out_shade_%0h", tag), bus.out_shade, exp_shade);
    @(negedge clk);
    check($sformatf("consumed_%0h", tag), bus.out_valid, 0);
    check($sformatf("idle_%0h", tag), busy, 0);
  endtask

  initial begin
    int n, herr, got, acc, last, terr, serr;
    logic pend;
    logic [TAG_W-1:0] next_tag, exp_tag;

    reset = 1'b1;
    abort = 1'b0;
    bus.req_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.eng_hit   = 1'b0;
    bus.eng_light = '0;
    drive_job('0, 16'h0000);
    repeat (2) @(negedge clk);
    check("req_ready_in_reset", bus.req_ready, 0);
    reset = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_eng_start", bus.eng_start, 0);
    check("rst_busy", busy, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("rst_out_shade", bus.out_shade, 0);
    check("rst_eng_px", bus.eng_px, 0);
    check("rst_req_ready", bus.req_ready, 1);
    @(negedge clk);

    run_job(10'h155, 16'h1000, 16'h0A40, 1'b1, 4'd10);
    run_job(10'h001, 16'h2000, 16'h7FFF, 1'b1, 4'd15);
    run_job(10'h002, 16'h3000, 16'hFF00, 1'b1, 4'd0);
    run_job(10'h003, 16'h4000, 16'h0500, 1'b0, 4'd0);
    run_job(10'h3FF, 16'h5000, 16'h0F80, 1'b1, 4'd15);
    run_job(10'h004, 16'h6000, 16'h1000, 1'b1, 4'd15);

    // backpressure: result must hold while a new job waits
    drive_job(10'h02A, 16'h0100);
    bus.eng_light = 16'h0A40;
    bus.eng_hit   = 1'b1;
    bus.out_ready = 1'b0;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("bp_latency", n, STEPS + 1);
    drive_job(10'h02B, 16'h0200);
    bus.req_valid = 1'b1;
    bus.eng_light = 16'h0300;
    herr = 0;
    repeat (20) begin
      @(negedge clk);
      if (!bus.out_valid || bus.out_tag !== 10'h02A || bus.out_shade !== 4'd10 ||
          !bus.out_hit || bus.req_ready || bus.eng_start) herr++;
    end
    check("bp_hold", herr, 0);
    bus.out_ready = 1'b1;
    #1 check("bp_req_ready", bus.req_ready, 1);
    @(negedge clk);
    check("bp_restart_start", bus.eng_start, 1);
    check("bp_out_valid_drop", bus.out_valid, 0);
    check("bp_new_operand", bus.eng_px, 16'h0200);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("bp2_latency", n, STEPS + 1);
    check("bp2_tag", bus.out_tag, 10'h02B);
    check("bp2_shade", bus.out_shade, 4'd3);
    @(negedge clk);
    check("bp2_consumed", bus.out_valid, 0);

    // back-to-back stream of 16 jobs
    next_tag = 10'h100;
    exp_tag  = 10'h100;
    got = 0; acc = 0; last = -1; terr = 0; serr = 0;
    drive_job(next_tag, 16'h0700);
    bus.eng_light = 16'h0300;
    bus.eng_hit   = 1'b1;
    bus.out_ready = 1'b1;
    bus.req_valid = 1'b1;
    #1;
    for (int c = 0; c < 400 && got < 16; c++) begin
      pend = bus.req_valid && bus.req_ready;
      @(negedge clk);
      if (pend) begin
        acc++;
        next_tag++;
        bus.req_tag = next_tag;
        if (acc == 16) bus.req_valid = 1'b0;
      end
      if (bus.out_valid) begin
        if (bus.out_tag !== exp_tag || bus.out_shade !== 4'd3) terr++;
        exp_tag++;
        if (last >= 0 && c - last != STEPS + 2) serr++;
        last = c;
        got++;
      end
    end
    check("stream_results", got, 16);
    check("stream_accepts", acc, 16);
    check("stream_tag_order", terr, 0);
    check("stream_spacing", serr, 0);
    @(negedge clk);
    check("stream_drained", bus.out_valid, 0);
    check("stream_idle", busy, 0);

    // abort while marching, counter at 4
    drive_job(10'h0A0, 16'h0800);
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    #1 check("abort_march_req_ready", bus.req_ready, 0);
    @(negedge clk);
    abort = 1'b0;
    check("abort_march_busy", busy, 0);
    check("abort_march_out_valid", bus.out_valid, 0);
    #1 check("abort_march_ready_after", bus.req_ready, 1);
    n = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid || bus.eng_start) n++;
    end
    check("abort_march_no_result", n, 0);

    // abort while holding a result, with a competing job offered
    drive_job(10'h0B0, 16'h0900);
    bus.out_ready = 1'b0;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("abort_done_latency", n, STEPS + 1);
    drive_job(10'h0B1, 16'h0A00);
    bus.req_valid = 1'b1;
    bus.out_ready = 1'b1;
    abort = 1'b1;
    #1 check("abort_done_req_ready", bus.req_ready, 0);
    @(negedge clk);
    abort = 1'b0;
    bus.req_valid = 1'b0;
    check("abort_done_out_valid", bus.out_valid, 0);
    check("abort_done_busy", busy, 0);
    check("abort_done_no_accept", bus.eng_start, 0);
    n = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid || bus.eng_start) n++;
    end
    check("abort_done_no_result", n, 0);

    // reset mid-march clears everything
    drive_job(10'h0C0, 16'h0B00);
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_out_valid", bus.out_valid, 0);
    check("rst_mid_eng_px", bus.eng_px, 0);
    check("rst_mid_out_tag", bus.out_tag, 0);
    #1 check("rst_mid_ready_after", bus.req_ready, 1);
    n = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid || bus.eng_start) n++;
    end
    check("rst_mid_no_result", n, 0);

    run_job(10'h0D0, 16'h0C00, 16'h0A40, 1'b1, 4'd10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
